// File: rtl/simon_seq_engine.sv
// rtl/simon_seq_engine.sv - Simon-says sequence engine; optional shortening notes via SIMON_SPEEDUP_EN
module simon_seq_engine #(
    parameter int          KEY_W         = 3,
    parameter int          MAX_LEN       = 16,
    parameter int          TICK_DIV      = 12500000,
    parameter int          NOTE_TICKS    = 4,
    parameter int          GAP_TICKS     = 2,
    parameter int          TIMEOUT_TICKS = 20,
    parameter int          SCORE_W       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             key_down,
    input  logic [KEY_W-1:0]                 key_code,
    output logic                             note_en,
    output logic [KEY_W-1:0]                 note_out,
    output logic [3:0]                       state,
    output logic [$clog2(MAX_LEN+1)-1:0]     seq_len,
    output logic [SCORE_W-1:0]               score,
    output logic                             fail,
    output logic                             win
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int DEPTH = 1 << LEN_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T1    = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TMAX  = (T1 > TIMEOUT_TICKS) ? T1 : TIMEOUT_TICKS;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADD       = 4'd1,
        S_PLAY_NOTE = 4'd2,
        S_PLAY_GAP  = 4'd3,
        S_USER_WAIT = 4'd4,
        S_USER_HOLD = 4'd5,
        S_ROUND_OK  = 4'd6,
        S_FAIL      = 4'd7,
        S_WIN       = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   index, index_d, seq_len_d, idx_inc;
    logic [SCORE_W-1:0] score_d;
    logic [CNT_W-1:0]   tick_cnt;
    logic [TW-1:0]      tcnt;
    logic [TW-1:0]      note_len;
    logic               tick;
    logic               key_down_q;
    logic               press;
    logic [15:0]        lfsr;
    logic [KEY_W-1:0]   new_note;
    logic [KEY_W-1:0]   seq [DEPTH];
    logic               seq_wr;
    logic               note_en_d;
    logic [KEY_W-1:0]   note_out_d;

    assign state    = state_q;
    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign press    = key_down & ~key_down_q;
    assign new_note = lfsr[KEY_W-1:0];
    assign idx_inc  = index + LEN_W'(1);

`ifdef SIMON_SPEEDUP_EN
    int eff_ticks;

    // Later rounds play shorter notes: one tick less per four notes, never below one tick.
    always_comb begin
        eff_ticks = NOTE_TICKS - int'(seq_len >> 2);
        if (eff_ticks < 1) begin
            eff_ticks = 1;
        end
    end

    // Note length is fixed at ADD so a whole playback uses one length.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            note_len <= TW'(NOTE_TICKS);
        end else if (state_q == S_ADD) begin
            note_len <= TW'(eff_ticks);
        end
    end
`else
    assign note_len = TW'(NOTE_TICKS);
`endif

    // Next-state logic and the values the registered outputs take on the next edge.
    always_comb begin
        state_d    = state_q;
        index_d    = index;
        seq_len_d  = seq_len;
        score_d    = score;
        seq_wr     = 1'b0;
        note_en_d  = 1'b0;
        note_out_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADD;
            end
            S_ADD: begin
                seq_wr    = 1'b1;
                seq_len_d = seq_len + LEN_W'(1);
                index_d   = '0;
                state_d   = S_PLAY_NOTE;
            end
            S_PLAY_NOTE: begin
                if (tick && tcnt == note_len - TW'(1)) state_d = S_PLAY_GAP;
            end
            S_PLAY_GAP: begin
                if (tick && tcnt == TW'(GAP_TICKS - 1)) begin
                    if (idx_inc == seq_len) begin
                        index_d = '0;
                        state_d = S_USER_WAIT;
                    end else begin
                        index_d = idx_inc;
                        state_d = S_PLAY_NOTE;
                    end
                end
            end
            S_USER_WAIT: begin
                // A press beats a timeout landing in the same cycle.
                if (press) begin
                    state_d = (key_code == seq[index]) ? S_USER_HOLD : S_FAIL;
                end else if (tick && tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                    state_d = S_FAIL;
                end
            end
            S_USER_HOLD: begin
                if (!key_down) begin
                    index_d = idx_inc;
                    if (idx_inc == seq_len) begin
                        state_d = S_ROUND_OK;
                        score_d = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
                    end else begin
                        state_d = S_USER_WAIT;
                    end
                end
            end
            S_ROUND_OK: begin
                if (tick && tcnt == TW'(GAP_TICKS - 1)) begin
                    state_d = (seq_len == LEN_W'(MAX_LEN)) ? S_WIN : S_ADD;
                end
            end
            S_FAIL, S_WIN: begin
                if (start) begin
                    seq_len_d = '0;
                    score_d   = '0;
                    index_d   = '0;
                    state_d   = S_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        note_en_d = (state_d == S_PLAY_NOTE) || (state_d == S_USER_HOLD);
        if (state_d == S_PLAY_NOTE) begin
            // The first note of a fresh game is being written this cycle, so forward it.
            note_out_d = (seq_wr && seq_len == '0) ? new_note : seq[index_d];
        end else if (state_d == S_USER_HOLD) begin
            note_out_d = (state_q == S_USER_WAIT) ? key_code : note_out;
        end
    end

    // State, counters, LFSR and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= S_IDLE;
            index      <= '0;
            seq_len    <= '0;
            score      <= '0;
            tick_cnt   <= '0;
            tcnt       <= '0;
            key_down_q <= 1'b0;
            lfsr       <= LFSR_SEED;
            note_en    <= 1'b0;
            note_out   <= '0;
            fail       <= 1'b0;
            win        <= 1'b0;
        end else begin
            state_q    <= state_d;
            index      <= index_d;
            seq_len    <= seq_len_d;
            score      <= score_d;
            key_down_q <= key_down;
            lfsr       <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
            note_en    <= note_en_d;
            note_out   <= note_out_d;
            fail       <= (state_d == S_FAIL);
            win        <= (state_d == S_WIN);
            if (state_d != state_q) begin
                tick_cnt <= '0;
                tcnt     <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                tcnt     <= tcnt + TW'(1);
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    // Note storage needs no reset: only entries below seq_len are ever read.
    always_ff @(posedge clk) begin
        if (!reset_n && seq_wr) begin
            seq[seq_len] <= new_note;
        end
    end

endmodule

// File: tb/tb_simon_seq_engine.sv
// tb/tb_simon_seq_engine.sv - self-checking bench for simon_seq_engine
module tb_simon_seq_engine;

`ifdef SIMON_SPEEDUP_EN
    localparam int TB_MAX_LEN = 6;
`else
    localparam int TB_MAX_LEN = 3;
`endif
    localparam logic [15:0] SEED = 16'hACE1;

    logic                              clk;
    logic                              reset_n;
    logic                              start;
    logic                              key_down;
    logic [2:0]                        key_code;
    logic                              note_en;
    logic [2:0]                        note_out;
    logic [3:0]                        state;
    logic [$clog2(TB_MAX_LEN+1)-1:0]   seq_len;
    logic [7:0]                        score;
    logic                              fail;
    logic                              win;

    simon_seq_engine #(
        .KEY_W(3), .MAX_LEN(TB_MAX_LEN), .TICK_DIV(2), .NOTE_TICKS(2),
        .GAP_TICKS(1), .TIMEOUT_TICKS(8), .SCORE_W(8), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_down(key_down),
        .key_code(key_code), .note_en(note_en), .note_out(note_out),
        .state(state), .seq_len(seq_len), .score(score), .fail(fail), .win(win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] m_lfsr;
    logic [2:0]  seq_m [8];
    int          slen = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    always @(posedge clk) m_lfsr <= reset_n ? SEED : lfsr_next(m_lfsr);

    function automatic int note_cycles(input int len);
        int t;
        t = 2;
`ifdef SIMON_SPEEDUP_EN
        t = 2 - (len - 1) / 4;
        if (t < 1) t = 1;
`endif
        return t * 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b1; start = 1'b0; key_down = 1'b0; key_code = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_note_en", note_en, 0);
        check("rst_note_out", note_out, 0);
        check("rst_seq_len", seq_len, 0);
        check("rst_score", score, 0);
        check("rst_fail", fail, 0);
        check("rst_win", win, 0);
        reset_n = 1'b0;
        slen = 0;
    endtask

    // Called at the negedge where the DUT is in ADD; returns in USER_WAIT.
    task automatic add_and_play(input bit hold);
        check("add_state", state, 1);
        seq_m[slen] = m_lfsr[2:0];
        slen++;
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < slen; i++) begin
            for (int c = 0; c < note_cycles(slen); c++) begin
                check("play_state", state, 2);
                check("play_en", note_en, 1);
                check("play_note", note_out, seq_m[i]);
                @(negedge clk);
            end
            for (int c = 0; c < 2; c++) begin
                if (hold && i == slen - 1 && c == 0) begin
                    key_down = 1'b1; key_code = seq_m[0];
                end
                check("gap_state", state, 3);
                check("gap_en", note_en, 0);
                @(negedge clk);
            end
        end
        check("wait_state", state, 4);
        check("wait_len", seq_len, slen);
    endtask

    task automatic press_release(input logic [2:0] k, input bit last);
        key_down = 1'b1; key_code = k;
        @(negedge clk);
        check("hold_state", state, 5);
        check("hold_en", note_en, 1);
        check("hold_note", note_out, k);
        key_down = 1'b0;
        @(negedge clk);
        check("release_state", state, last ? 6 : 4);
    endtask

    typedef struct {
        logic       st_in;
        logic       kd;
        logic [2:0] kc;
        int         reps;
        logic [3:0] exp_state;
        logic       exp_en;
        int         exp_len;
        logic       exp_fail;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // start, play one note, time out in USER_WAIT, restart from FAIL
        tbl[0] = '{1'b1, 1'b0, 3'd0, 1,  4'd1, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 4,  4'd2, 1'b1, 1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 3'd0, 2,  4'd3, 1'b0, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 3'd0, 16, 4'd4, 1'b0, 1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 1,  4'd7, 1'b0, 1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 3'd0, 1,  4'd1, 1'b0, 0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 3'd0, 4,  4'd2, 1'b1, 1, 1'b0};

        do_reset();
        for (int r = 0; r < 7; r++) begin
            start = tbl[r].st_in; key_down = tbl[r].kd; key_code = tbl[r].kc;
            for (int c = 0; c < tbl[r].reps; c++) begin
                @(negedge clk);
                check($sformatf("tbl%0d_state", r), state, tbl[r].exp_state);
                check($sformatf("tbl%0d_en", r), note_en, tbl[r].exp_en);
                check($sformatf("tbl%0d_len", r), seq_len, tbl[r].exp_len);
                check($sformatf("tbl%0d_fail", r), fail, tbl[r].exp_fail);
            end
        end

        // Full game to WIN
        do_reset();
        start = 1'b1;
        @(negedge clk);
        for (int r = 1; r <= TB_MAX_LEN; r++) begin
            add_and_play(1'b0);
            for (int i = 0; i < r; i++) press_release(seq_m[i], i == r - 1);
            check("round_score", score, r);
            @(negedge clk);
            check("round_ok_2nd", state, 6);
            @(negedge clk);
            if (r < TB_MAX_LEN) check("next_add", state, 1);
        end
        check("win_state", state, 8);
        check("win_flag", win, 1);
        check("win_note_en", note_en, 0);

        // Wrong key fails immediately, then restart
        do_reset();
        start = 1'b1;
        @(negedge clk);
        add_and_play(1'b0);
        key_down = 1'b1; key_code = seq_m[0] ^ 3'd1;
        @(negedge clk);
        check("wrong_state", state, 7);
        check("wrong_fail", fail, 1);
        check("wrong_score", score, 0);
        key_down = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        slen = 0;
        add_and_play(1'b0);

        // Correct press on the last cycle before timeout wins
        do_reset();
        start = 1'b1;
        @(negedge clk);
        add_and_play(1'b0);
        repeat (15) @(negedge clk);
        check("late_wait", state, 4);
        key_down = 1'b1; key_code = seq_m[0];
        @(negedge clk);
        check("late_press_state", state, 5);
        check("late_press_fail", fail, 0);
        key_down = 1'b0;
        @(negedge clk);
        check("late_release", state, 6);

        // Key held from PLAY_GAP is not a press; then hold 5 cycles
        do_reset();
        start = 1'b1;
        @(negedge clk);
        add_and_play(1'b1);
        repeat (3) begin
            @(negedge clk);
            check("held_stays_wait", state, 4);
        end
        key_down = 1'b0;
        @(negedge clk);
        check("held_release", state, 4);
        key_down = 1'b1; key_code = seq_m[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold5_state", state, 5);
            check("hold5_en", note_en, 1);
            check("hold5_note", note_out, seq_m[0]);
        end
        key_down = 1'b0;
        @(negedge clk);
        check("hold5_done", state, 6);
        check("hold5_score", score, 1);

        // Reset in the middle of round-2 playback
        repeat (2) @(negedge clk);
        check("r2_add", state, 1);
        repeat (2) @(negedge clk);
        check("r2_play", state, 2);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_state", state, 0);
        check("midrst_en", note_en, 0);
        check("midrst_note", note_out, 0);
        check("midrst_len", seq_len, 0);
        check("midrst_score", score, 0);
        reset_n = 1'b0;
        slen = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
- Parametrised Simon-says game engine: grows a random note sequence, plays it back with timed notes, then checks the player's key entry with a timeout.
- Generalises the fixed 8-key/100-bit game FSM+datapath: configurable key count, sequence depth and timing, plus win detection and an entry timeout.
- Sits between the keyboard decoder (key_down/key_code) and the audio tone generator (note_en/note_out); drives score/state for the HEX decoders.

Parameters:
- KEY_W, 3, key code width; 2^KEY_W keys.
- MAX_LEN, 16, maximum sequence length (buffer depth); reaching it wins.
- TICK_DIV, 12500000, clk cycles per time tick (>=1).
- NOTE_TICKS, 4, ticks each played note sounds (>=1).
- GAP_TICKS, 2, silent ticks after each played note and after a completed round (>=1).
- TIMEOUT_TICKS, 20, ticks allowed in USER_WAIT before failing.
- SCORE_W, 8, score width.
- LFSR_SEED, 16'hACE1, nonzero 16-bit seed.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-high reset (name kept for codebase consistency; 1 = reset).
- start  in  1  begin/restart game; sampled each cycle.
- key_down  in  1  level: a key is held.
- key_code  in  KEY_W  code of held key; valid while key_down=1.
- note_en  out  1  tone generator enable.
- note_out  out  KEY_W  note to sound.
- state  out  4  current FSM state code.
- seq_len  out  clog2(MAX_LEN+1)  current sequence length.
- score  out  SCORE_W  completed rounds.
- fail  out  1  high while in FAIL.
- win  out  1  high while in WIN.

Behaviour:
- Reset (reset_n=1 at clk edge): state=IDLE, note_en=0, note_out=0, seq_len=0, score=0, fail=0, win=0, index=0, tick counter=0, key_down_q=0, LFSR=LFSR_SEED. Reset has priority over everything, including mid-playback or mid-entry.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every non-reset cycle. New note = lfsr[KEY_W-1:0].
- Tick: counter counts 0..TICK_DIV-1 and pulses on TICK_DIV-1. Cleared on every state change, so each timed state lasts exactly N*TICK_DIV cycles.
- Key press = rising edge, key_down & ~key_down_q (registered). A key already held when USER_WAIT is entered is not a press.
- States (code):
  - IDLE(0): start -> ADD.
  - ADD(1): one cycle. seq[seq_len] <= new note, seq_len++, index=0 -> PLAY_NOTE.
  - PLAY_NOTE(2): note_en=1, note_out=seq[index]. After NOTE_TICKS ticks -> PLAY_GAP.
  - PLAY_GAP(3): note_en=0. After GAP_TICKS ticks, index++. If the new index==seq_len: index=0 -> USER_WAIT, else -> PLAY_NOTE.
  - USER_WAIT(4): note_en=0.
    - Press with key_code==seq[index]: latch the code -> USER_HOLD.
    - Press with a mismatched code -> FAIL.
    - TIMEOUT_TICKS ticks with no press -> FAIL.
    - Press and timeout in the same cycle: the press wins.
  - USER_HOLD(5): note_en=1, note_out=latched code. On key_down=0: index++. If the new index==seq_len -> ROUND_OK, else -> USER_WAIT (timeout restarts).
  - ROUND_OK(6): entry cycle does score++, saturating at 2^SCORE_W-1. After GAP_TICKS ticks: if seq_len==MAX_LEN -> WIN, else -> ADD.
  - FAIL(7): fail=1. start -> clear seq_len/score/index -> ADD.
  - WIN(8): win=1. start -> same restart as FAIL.
- start is ignored in states 1-6.
- Latency: start high at edge n -> state=ADD after edge n; note_en=1 after edge n+1.
- Outputs are registered. note_out=0 whenever note_en=0.

Optional Feature:
- SIMON_SPEEDUP_EN defined: effective note length = max(1, NOTE_TICKS - (seq_len-1)/4). Computed at ADD, held for the whole playback.
- Not defined: every played note lasts NOTE_TICKS ticks.

Test Plan:
Common parameters: TICK_DIV=2, NOTE_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=8, MAX_LEN=3, KEY_W=3.
- Reset, then 1-cycle start -> state 1 for one cycle, then state 2 with note_en=1 for 4 cycles, note_out = model LFSR[2:0] at the ADD cycle. Then state 3 for 2 cycles, then state 4; seq_len=1.
- Correct press/release every round for 3 rounds -> score=1,2,3. After the final ROUND_OK (2 cycles): state=8, win=1, note_en=0.
- Round 1: press a code != seq[0] -> FAIL on the next edge, fail=1, score=0. Pulse start -> seq_len=1, score=0, state 1.
- Enter USER_WAIT with no press -> state=7 exactly 16 cycles after entry. Same test with a correct press on cycle 16 -> state 5, no FAIL.
- key_down held high since PLAY_GAP -> stays in state 4 until release and re-press. Hold 5 cycles -> note_en=1, note_out=key for those cycles.
- Assert reset_n for 1 cycle mid state 2 -> next state=0, note_en=0, seq_len=0, score=0. With SIMON_SPEEDUP_EN and NOTE_TICKS=2, MAX_LEN=6: round-5 notes last 1 tick (2 cycles).
